// File: rtl/ip_sel_ctrl.sv
// ============================================================================
// Module   : ip_sel_ctrl
// Function : Debounced, sequenced run-time switch of the active IP behind the
//            shared pad mux. Optional macro IP_SEL_LOCK_EN adds a lock_i input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ip_sel_ctrl #(
  parameter int                SEL_W        = 3,
  parameter int                NUM_IP       = 8,
  parameter logic [NUM_IP-1:0] VALID_MASK   = 8'b0010_1111,
  parameter logic [SEL_W-1:0]  RESET_SEL    = 3'd1,
  parameter int                DEBOUNCE_CYC = 16,
  parameter int                QUIESCE_CYC  = 4,
  parameter int                RST_HOLD_CYC = 8
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_n_i,
  input  logic [SEL_W-1:0]  ip_sel_raw_i,
`ifdef IP_SEL_LOCK_EN
  input  logic              lock_i,
`endif
  output logic [SEL_W-1:0]  ip_sel_o,
  output logic              pad_oe_en_o,
  output logic [NUM_IP-1:0] ip_rst_n_o,
  output logic [NUM_IP-1:0] ip_clk_en_o,
  output logic              busy_o,
  output logic              sel_err_o,
  output logic [7:0]        switch_cnt_o
);

  localparam int DB_W    = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TMR_MAX = (QUIESCE_CYC > RST_HOLD_CYC) ? QUIESCE_CYC : RST_HOLD_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [DB_W-1:0]  c_db_max = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] c_q_last = TMR_W'(QUIESCE_CYC - 1);
  localparam logic [TMR_W-1:0] c_h_last = TMR_W'(RST_HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_QUIESCE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
  logic [SEL_W-1:0]   r_sync1, r_sync2, r_sync_prev;
  logic [DB_W-1:0]    r_db_cnt, w_db_nxt;
  logic               r_err_armed, w_armed_nxt;
  logic [SEL_W-1:0]   r_cand, w_cand_nxt;
  logic [SEL_W-1:0]   r_ip_sel, w_sel_nxt;
  logic               r_pad_oe, r_busy, r_sel_err, w_err;
  logic [NUM_IP-1:0]  r_ip_rst_n, r_ip_clk_en, w_onehot;
  logic [7:0]         r_switch_cnt, w_cnt_nxt;
  logic               w_stable, w_lock, w_live;

`ifdef IP_SEL_LOCK_EN
  assign w_lock = lock_i;
`else
  assign w_lock = 1'b0;
`endif

  assign w_stable = (r_sync2 == r_sync_prev);

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr + 1'b1;
    w_db_nxt    = '0;
    w_armed_nxt = 1'b1;
    w_cand_nxt  = r_cand;
    w_sel_nxt   = r_ip_sel;
    w_err       = 1'b0;
    w_cnt_nxt   = r_switch_cnt;
    case (r_state)
      ST_BOOT: begin
        if (r_tmr == c_h_last) begin
          w_state_nxt = ST_RELEASE;
          w_tmr_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_tmr_nxt   = '0;
        w_armed_nxt = r_err_armed | ~w_stable;
        if (!w_stable)
          w_db_nxt = '0;
        else if (r_db_cnt == c_db_max)
          w_db_nxt = r_db_cnt;
        else
          w_db_nxt = r_db_cnt + 1'b1;
        // A confirmed code must have stayed put through the final compare too
        if (w_stable && (r_db_cnt == c_db_max) && (r_sync2 != r_ip_sel)) begin
          w_db_nxt = '0;
          if (VALID_MASK[r_sync2] && !w_lock) begin
            w_state_nxt = ST_QUIESCE;
            w_cand_nxt  = r_sync2;
          end else begin
            w_err       = r_err_armed;
            w_armed_nxt = 1'b0;
          end
        end
      end
      ST_QUIESCE: begin
        if (r_tmr == c_q_last) begin
          w_state_nxt = ST_HOLD;
          w_tmr_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (r_tmr == c_h_last) begin
          w_state_nxt = ST_RELEASE;
          w_tmr_nxt   = '0;
          w_sel_nxt   = r_cand;
          if (r_switch_cnt != 8'hFF)
            w_cnt_nxt = r_switch_cnt + 8'd1;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_RUN;
        w_tmr_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with r_state
  assign w_onehot = {{(NUM_IP-1){1'b0}}, 1'b1} << w_sel_nxt;
  assign w_live   = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_QUIESCE) ||
                    (w_state_nxt == ST_RELEASE);

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_state      <= ST_BOOT;
      r_tmr        <= '0;
      r_sync1      <= RESET_SEL;
      r_sync2      <= RESET_SEL;
      r_sync_prev  <= RESET_SEL;
      r_db_cnt     <= '0;
      r_err_armed  <= 1'b1;
      r_cand       <= RESET_SEL;
      r_ip_sel     <= RESET_SEL;
      r_pad_oe     <= 1'b0;
      r_busy       <= 1'b1;
      r_sel_err    <= 1'b0;
      r_ip_rst_n   <= '0;
      r_ip_clk_en  <= '0;
      r_switch_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmr        <= w_tmr_nxt;
      r_sync1      <= ip_sel_raw_i;
      r_sync2      <= r_sync1;
      r_sync_prev  <= r_sync2;
      r_db_cnt     <= w_db_nxt;
      r_err_armed  <= w_armed_nxt;
      r_cand       <= w_cand_nxt;
      r_ip_sel     <= w_sel_nxt;
      r_pad_oe     <= (w_state_nxt == ST_RUN);
      r_busy       <= (w_state_nxt != ST_RUN);
      r_sel_err    <= w_err;
      r_ip_rst_n   <= w_live ? w_onehot : '0;
      r_ip_clk_en  <= w_live ? w_onehot : '0;
      r_switch_cnt <= w_cnt_nxt;
    end
  end

  assign ip_sel_o     = r_ip_sel;
  assign pad_oe_en_o  = r_pad_oe;
  assign ip_rst_n_o   = r_ip_rst_n;
  assign ip_clk_en_o  = r_ip_clk_en;
  assign busy_o       = r_busy;
  assign sel_err_o    = r_sel_err;
  assign switch_cnt_o = r_switch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ip_sel_ctrl.sv
// ============================================================================
// Module   : tb_ip_sel_ctrl
// Function : Directed self-checking bench for ip_sel_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ip_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw = 3'd1;
`ifdef IP_SEL_LOCK_EN
  logic       lock = 1'b0;
`endif
  logic [2:0] sel;
  logic       pad_oe, busy, sel_err;
  logic [7:0] ip_rst_n, ip_clk_en, sw_cnt;

  int total = 0;
  int bad   = 0;
  int errs, busys;

  ip_sel_ctrl dut (
    .sys_clk_i    (clk),
    .sys_rst_n_i  (rst_n),
    .ip_sel_raw_i (raw),
`ifdef IP_SEL_LOCK_EN
    .lock_i       (lock),
`endif
    .ip_sel_o     (sel),
    .pad_oe_en_o  (pad_oe),
    .ip_rst_n_o   (ip_rst_n),
    .ip_clk_en_o  (ip_clk_en),
    .busy_o       (busy),
    .sel_err_o    (sel_err),
    .switch_cnt_o (sw_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    tick(2);
    chk("rst_sel", sel, 3'd1);
    chk("rst_pad", pad_oe, 1'b0);
    chk("rst_rstn", ip_rst_n, 8'h00);
    chk("rst_clken", ip_clk_en, 8'h00);
    chk("rst_busy", busy, 1'b1);
    chk("rst_err", sel_err, 1'b0);
    chk("rst_cnt", sw_cnt, 8'd0);

    // Boot: 8 BOOT cycles, RELEASE, then RUN
    rst_n = 1'b1;
    tick(7);
    chk("boot_hold_rstn", ip_rst_n, 8'h00);
    tick(1);
    chk("boot_rel_rstn", ip_rst_n, 8'h02);
    chk("boot_rel_clken", ip_clk_en, 8'h02);
    chk("boot_rel_pad", pad_oe, 1'b0);
    tick(1);
    chk("boot_run_pad", pad_oe, 1'b1);
    chk("boot_run_busy", busy, 1'b0);
    chk("boot_cnt", sw_cnt, 8'd0);

    // Switch 1 -> 2
    raw = 3'd2;
    tick(18);
    chk("sw12_pre_pad", pad_oe, 1'b1);
    tick(1);
    chk("sw12_q_pad", pad_oe, 1'b0);
    chk("sw12_q_busy", busy, 1'b1);
    chk("sw12_q_rstn", ip_rst_n, 8'h02);
    tick(4);
    chk("sw12_h_rstn", ip_rst_n, 8'h00);
    chk("sw12_h_clken", ip_clk_en, 8'h00);
    tick(7);
    chk("sw12_h_end_rstn", ip_rst_n, 8'h00);
    tick(1);
    chk("sw12_rel_sel", sel, 3'd2);
    chk("sw12_rel_rstn", ip_rst_n, 8'h04);
    chk("sw12_rel_cnt", sw_cnt, 8'd1);
    chk("sw12_rel_pad", pad_oe, 1'b0);
    tick(1);
    chk("sw12_run_pad", pad_oe, 1'b1);

    // Bouncing code never confirms
    for (int i = 0; i < 4; i++) begin
      raw = (i % 2 == 0) ? 3'd1 : 3'd2;
      tick(10);
      chk("bounce_busy", busy, 1'b0);
    end
    tick(30);
    chk("bounce_sel", sel, 3'd2);
    chk("bounce_cnt", sw_cnt, 8'd1);
    chk("bounce_pad", pad_oe, 1'b1);

    // Unpopulated slot 4: single error pulse
    raw = 3'd4;
    errs = 0;
    busys = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (sel_err) errs++;
      if (busy) busys++;
    end
    chk("inv_err_pulses", errs, 1);
    chk("inv_busy_cycles", busys, 0);
    chk("inv_sel", sel, 3'd2);
    chk("inv_rstn", ip_rst_n, 8'h04);
    raw = 3'd2;
    tick(20);

    // Switch 2 -> 1 with a pad change to 3 during HOLD
    raw = 3'd1;
    tick(19);
    chk("sw21_q_pad", pad_oe, 1'b0);
    tick(4);
    chk("sw21_h_rstn", ip_rst_n, 8'h00);
    tick(2);
    raw = 3'd3;
    tick(6);
    chk("sw21_rel_sel", sel, 3'd1);
    chk("sw21_rel_rstn", ip_rst_n, 8'h02);
    chk("sw21_rel_cnt", sw_cnt, 8'd2);
    tick(1);
    chk("sw21_run_pad", pad_oe, 1'b1);
    tick(15);
    chk("sw13_debounce_busy", busy, 1'b0);
    tick(1);
    chk("sw13_q_busy", busy, 1'b1);
    tick(13);
    chk("sw13_sel", sel, 3'd3);
    chk("sw13_rstn", ip_rst_n, 8'h08);
    chk("sw13_clken", ip_clk_en, 8'h08);
    chk("sw13_pad", pad_oe, 1'b1);
    chk("sw13_cnt", sw_cnt, 8'd3);

    // Reset asserted during HOLD of a 3 -> 0 switch
    raw = 3'd0;
    tick(25);
    chk("mid_h_rstn", ip_rst_n, 8'h00);
    chk("mid_h_busy", busy, 1'b1);
    rst_n = 1'b0;
    raw = 3'd1;
    #1;
    chk("mid_rst_sel", sel, 3'd1);
    chk("mid_rst_pad", pad_oe, 1'b0);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_cnt", sw_cnt, 8'd0);
    chk("mid_rst_clken", ip_clk_en, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    chk("reboot_sel", sel, 3'd1);
    chk("reboot_rstn", ip_rst_n, 8'h02);
    chk("reboot_pad0", pad_oe, 1'b0);
    tick(1);
    chk("reboot_pad1", pad_oe, 1'b1);
    chk("reboot_cnt", sw_cnt, 8'd0);
    chk("reboot_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
